// File: rtl/meas_disp_pkg.sv
// Shared constants and FSM state type for the measurement digit formatter.
package meas_disp_pkg;
  localparam int FREQ_DIGITS = 6;
  localparam int VPP_DIGITS  = 3;
  localparam int FREQ_MAX    = 999999;
  localparam int VPP_MAX     = 999;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    PEND = 2'd2
  } state_t;
endpackage

// File: rtl/bin2bcd_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left
// by one with the next binary bit entering at the LSB.
module bin2bcd_step #(
  parameter int N = 6
) (
  input  logic [4*N-1:0] bcd,
  input  logic           shift_in,
  output logic [4*N-1:0] bcd_next
);
  logic [4*N-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < N; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_next = (adj << 1) | {{(4*N-1){1'b0}}, shift_in};
endmodule

// File: rtl/meas_digit_formatter.sv
// Converts binary frequency/Vpp to glyph digit codes with iterative double-dabble,
// committing results to the display registers only on a vsync falling edge.
module meas_digit_formatter
  import meas_disp_pkg::*;
#(
  parameter int         FREQ_W     = 20,
  parameter int         VPP_W      = 10,
  parameter int         LZ_BLANK   = 1,
  parameter logic [3:0] BLANK_CODE = meas_disp_pkg::BLANK_CODE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FREQ_W-1:0] freq_bin,
  input  logic [VPP_W-1:0]  vpp_bin,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              vsync,
  output logic [3:0]        freq_d0,
  output logic [3:0]        freq_d1,
  output logic [3:0]        freq_d2,
  output logic [3:0]        freq_d3,
  output logic [3:0]        freq_d4,
  output logic [3:0]        freq_d5,
  output logic [3:0]        vpp_d0,
  output logic [3:0]        vpp_d1,
  output logic [3:0]        vpp_d2,
  output logic              freq_ovf,
  output logic              vpp_ovf,
  output logic              disp_valid
);
  localparam int FB = 4*FREQ_DIGITS;
  localparam int VB = 4*VPP_DIGITS;
  localparam int CW = $clog2(FREQ_W);
  localparam logic [CW-1:0] LAST = CW'(FREQ_W-1);

  function automatic logic [FREQ_W:0] sat_freq(input logic [FREQ_W-1:0] v);
    if (v > FREQ_W'(FREQ_MAX)) return {1'b1, FREQ_W'(FREQ_MAX)};
    return {1'b0, v};
  endfunction

  function automatic logic [VPP_W:0] sat_vpp(input logic [VPP_W-1:0] v);
    if (v > VPP_W'(VPP_MAX)) return {1'b1, VPP_W'(VPP_MAX)};
    return {1'b0, v};
  endfunction

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              vsync_prev, commit;
  logic [FREQ_W-1:0] freq_sh, vpp_sh;
  logic [FB-1:0]     freq_bcd, freq_bcd_next, pend_freq, freq_shown, freq_disp;
  logic [VB-1:0]     vpp_bcd, vpp_bcd_next, pend_vpp, vpp_shown, vpp_disp;
  logic              conv_freq_ovf, conv_vpp_ovf, pend_freq_ovf, pend_vpp_ovf;
  logic [FREQ_W:0]   freq_sat;
  logic [VPP_W:0]    vpp_sat;
  logic              transfer, lead_f, lead_v;

  assign in_ready = (state != CONV);
  assign transfer = in_valid && in_ready;
  assign freq_sat = sat_freq(freq_bin);
  assign vpp_sat  = sat_vpp(vpp_bin);

  bin2bcd_step #(.N(FREQ_DIGITS)) u_step_freq (
    .bcd(freq_bcd), .shift_in(freq_sh[FREQ_W-1]), .bcd_next(freq_bcd_next));
  bin2bcd_step #(.N(VPP_DIGITS)) u_step_vpp (
    .bcd(vpp_bcd), .shift_in(vpp_sh[FREQ_W-1]), .bcd_next(vpp_bcd_next));

  // Conversion datapath: no reset needed, state machine qualifies its contents
  always_ff @(posedge clk) begin
    if (transfer) begin
      freq_sh       <= freq_sat[FREQ_W-1:0];
      vpp_sh        <= {{(FREQ_W-VPP_W){1'b0}}, vpp_sat[VPP_W-1:0]};
      freq_bcd      <= '0;
      vpp_bcd       <= '0;
      conv_freq_ovf <= freq_sat[FREQ_W];
      conv_vpp_ovf  <= vpp_sat[VPP_W];
    end else if (state == CONV) begin
      freq_sh  <= freq_sh << 1;
      vpp_sh   <= vpp_sh << 1;
      freq_bcd <= freq_bcd_next;
      vpp_bcd  <= vpp_bcd_next;
      if (cnt == LAST) begin
        pend_freq     <= freq_bcd_next;
        pend_vpp      <= vpp_bcd_next;
        pend_freq_ovf <= conv_freq_ovf;
        pend_vpp_ovf  <= conv_vpp_ovf;
      end
    end
  end

  // Leading-zero blanking; the units digit is never blanked
  always_comb begin
    freq_shown = pend_freq;
    vpp_shown  = pend_vpp;
    lead_f     = (LZ_BLANK != 0);
    lead_v     = (LZ_BLANK != 0);
    for (int i = FREQ_DIGITS-1; i > 0; i--) begin
      if (lead_f && pend_freq[4*i +: 4] == 4'd0) freq_shown[4*i +: 4] = BLANK_CODE;
      else lead_f = 1'b0;
    end
    for (int i = VPP_DIGITS-1; i > 0; i--) begin
      if (lead_v && pend_vpp[4*i +: 4] == 4'd0) vpp_shown[4*i +: 4] = BLANK_CODE;
      else lead_v = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      vsync_prev <= 1'b1;
      commit     <= 1'b0;
      freq_disp  <= '0;
      vpp_disp   <= '0;
      freq_ovf   <= 1'b0;
      vpp_ovf    <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      vsync_prev <= vsync;
      commit     <= vsync_prev & ~vsync;
      if (transfer) cnt <= '0;
      else if (state == CONV) cnt <= cnt + 1'b1;
      case (state)
        IDLE: if (transfer) state <= CONV;
        CONV: if (cnt == LAST) state <= PEND;
        PEND: begin
          if (commit) begin
            freq_disp  <= freq_shown;
            vpp_disp   <= vpp_shown;
            freq_ovf   <= pend_freq_ovf;
            vpp_ovf    <= pend_vpp_ovf;
            disp_valid <= 1'b1;
          end
          if (transfer) state <= CONV;
          else if (commit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {freq_d5, freq_d4, freq_d3, freq_d2, freq_d1, freq_d0} = freq_disp;
  assign {vpp_d2, vpp_d1, vpp_d0} = vpp_disp;
endmodule

// File: tb/tb_meas_digit_formatter.sv
// Directed bench for meas_digit_formatter: blanking and non-blanking instances
// share one stimulus stream.
module tb_meas_digit_formatter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] freq_bin = '0;
  logic [9:0]  vpp_bin = '0;
  logic        in_valid = 1'b0;
  logic        vsync = 1'b1;
  logic        in_ready, in_ready_nb;
  logic [3:0]  f0, f1, f2, f3, f4, f5, v0, v1, v2;
  logic [3:0]  g0, g1, g2, g3, g4, g5, w0, w1, w2;
  logic        freq_ovf, vpp_ovf, disp_valid;
  logic        freq_ovf_nb, vpp_ovf_nb, disp_valid_nb;
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  meas_digit_formatter #(.LZ_BLANK(1)) dut (
    .clk(clk), .rst_n(rst_n), .freq_bin(freq_bin), .vpp_bin(vpp_bin),
    .in_valid(in_valid), .in_ready(in_ready), .vsync(vsync),
    .freq_d0(f0), .freq_d1(f1), .freq_d2(f2), .freq_d3(f3), .freq_d4(f4), .freq_d5(f5),
    .vpp_d0(v0), .vpp_d1(v1), .vpp_d2(v2),
    .freq_ovf(freq_ovf), .vpp_ovf(vpp_ovf), .disp_valid(disp_valid));

  meas_digit_formatter #(.LZ_BLANK(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .freq_bin(freq_bin), .vpp_bin(vpp_bin),
    .in_valid(in_valid), .in_ready(in_ready_nb), .vsync(vsync),
    .freq_d0(g0), .freq_d1(g1), .freq_d2(g2), .freq_d3(g3), .freq_d4(g4), .freq_d5(g5),
    .vpp_d0(w0), .vpp_d1(w1), .vpp_d2(w2),
    .freq_ovf(freq_ovf_nb), .vpp_ovf(vpp_ovf_nb), .disp_valid(disp_valid_nb));

  wire [23:0] freq_all    = {f5, f4, f3, f2, f1, f0};
  wire [11:0] vpp_all     = {v2, v1, v0};
  wire [23:0] freq_all_nb = {g5, g4, g3, g2, g1, g0};
  wire [11:0] vpp_all_nb  = {w2, w1, w0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] f, input logic [9:0] v);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("ready_before_send", 32'(in_ready), 32'd1);
    freq_bin = f;
    vpp_bin  = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // vsync low for one cycle; the registered edge commits one cycle later
  task automatic vfall();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
  endtask

  task automatic chk_disp(input string tag, input logic [23:0] ef, input logic [11:0] ev,
                          input logic eovf_f, input logic eovf_v, input logic edv);
    chk({tag, "_freq"}, 32'(freq_all), 32'(ef));
    chk({tag, "_vpp"}, 32'(vpp_all), 32'(ev));
    chk({tag, "_ovf"}, {30'd0, freq_ovf, vpp_ovf}, {30'd0, eovf_f, eovf_v});
    chk({tag, "_dvalid"}, 32'(disp_valid), 32'(edv));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cycles;
    #12;
    chk_disp("reset", 24'h0, 12'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("reset_ready", 32'(in_ready), 32'd1);

    // 1: 123456 / 50, busy window exactly 20 cycles
    send(20'd123456, 10'd50);
    low_cycles = 0;
    for (int i = 0; i < 25; i++) begin
      if (!in_ready) low_cycles++;
      tick();
    end
    chk("busy_cycles", 32'(low_cycles), 32'd20);
    chk_disp("pre_commit", 24'h0, 12'h0, 1'b0, 1'b0, 1'b0);
    vfall();
    chk_disp("t1", 24'h123456, 12'hF50, 1'b0, 1'b0, 1'b1);
    chk("t1_nb_freq", 32'(freq_all_nb), 32'h123456);
    chk("t1_nb_vpp", 32'(vpp_all_nb), 32'h050);

    // 2: saturation
    send(20'hFFFFF, 10'd1023);
    repeat (22) tick();
    vfall();
    chk_disp("t2", 24'h999999, 12'h999, 1'b1, 1'b1, 1'b1);

    // 3: zeros, blanked vs unblanked
    send(20'd0, 10'd0);
    repeat (22) tick();
    vfall();
    chk_disp("t3", 24'hFFFFF0, 12'hFF0, 1'b0, 1'b0, 1'b1);
    chk("t3_nb_freq", 32'(freq_all_nb), 32'h000000);
    chk("t3_nb_vpp", 32'(vpp_all_nb), 32'h000);

    // 4: newest wins, then hold on an empty commit
    send(20'd111111, 10'd11);
    repeat (22) tick();
    send(20'd222222, 10'd22);
    repeat (22) tick();
    vfall();
    chk_disp("t4", 24'h222222, 12'hF22, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    vfall();
    chk_disp("t4_hold", 24'h222222, 12'hF22, 1'b0, 1'b0, 1'b1);

    // 5: commit lands on the cycle CONV finishes
    send(20'd654321, 10'd7);
    repeat (18) tick();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    chk("t5_done_ready", 32'(in_ready), 32'd1);
    chk_disp("t5_race", 24'h222222, 12'hF22, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    vfall();
    chk_disp("t5", 24'h654321, 12'hFF7, 1'b0, 1'b0, 1'b1);

    // 6: asynchronous reset at conversion step 10
    send(20'd123, 10'd5);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    chk_disp("t6_rst", 24'h0, 12'h0, 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    tick();
    chk("t6_ready", 32'(in_ready), 32'd1);
    send(20'd999, 10'd0);
    repeat (22) tick();
    vfall();
    chk_disp("t6", 24'hFFF999, 12'hFF0, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
